csi2_rx_packet_parser: RTL and testbench
========================================

# csi2_rx_packet_parser

Parses the CSI-2 byte stream produced by the D-PHY lane aligner inside `top`, directly downstream of the camera D-PHY receive path and upstream of the pixel/line buffer that feeds HDMI. Decodes the 4-byte packet header, checks ECC and payload CRC, and emits frame/line sync pulses plus a qualified payload byte stream. Single clock domain, one byte per cycle maximum.

## Interface
- `VC_SEL`, 2'd0, virtual channel accepted; packets on other VCs are consumed silently, with no output.
- `CHECK_ECC`, 1, when 0 the header ECC compare is skipped and `ecc_err` never asserts.
- `clk`  in  1  byte clock from the D-PHY receive path.
- `areset_n`  in  1  asynchronous, active-low reset.
- `in_vld`  in  1  `in_dat` valid this cycle.
- `in_dat`  in  8  received byte, lane order already merged.
- `in_sot`  in  1  qualified by `in_vld`; marks header byte 0 of a packet.
- `in_eot`  in  1  pulse, end of HS burst (need not coincide with `in_vld`).
- `frame_start`, `frame_end`, `line_start`, `line_end`  out  1 each  one-cycle pulses for short packets with DT 0x00, 0x01, 0x02, 0x03.
- `pix_vld`  out  1  payload byte valid.
- `pix_dat`  out  8  payload byte.
- `pix_dt`  out  6  data type of the current long packet; held until the next header.
- `pix_last`  out  1  with `pix_vld`, final payload byte.
- `ecc_err`, `crc_err`, `trunc_err`  out  1 each  one-cycle error pulses.

## Operation
- Header layout: byte0 = DataID {VC[7:6], DT[5:0]}; byte1 = WC[7:0]; byte2 = WC[15:8]; byte3 = ECC.
- A packet is short when DT ≤ 0x0F and long otherwise. A long packet carries WC payload bytes followed by a 2-byte CRC, LSB first.
- ECC follows the CSI-2 6-bit Hamming code over the 24 header bits, with ECC[7:6] = 0. The block checks the ECC and does not correct it.
- CRC is CRC-16, polynomial x^16+x^12+x^5+1, reflected (LSB-first), init 0xFFFF. It is computed over the payload bytes only, with no final XOR.
- State machine:
  - IDLE: `in_vld & in_sot` → HDR, capturing byte0.
  - HDR: counts bytes 1..3. On byte3:
    - ECC mismatch → pulse `ecc_err` → IDLE, discarding the packet.
    - Short packet → pulse the matching sync output if VC matches → IDLE. Short DT 0x04–0x0F produce no output.
    - Long packet with WC > 0 → PAYLOAD. Load the 16-bit down-counter with WC, load CRC with 0xFFFF, latch `pix_dt`.
    - Long packet with WC = 0 → CRC.
  - PAYLOAD: each valid byte updates the CRC, decrements the counter, and is forwarded if VC matches. Counter reaching 0 → CRC state.
  - CRC: accepts 2 bytes and compares them to the computed CRC. Mismatch → `crc_err` pulse. Either way → IDLE.
- `in_sot` in any non-IDLE state: pulse `trunc_err`, abandon the current packet, and treat the byte as byte0 of a new header (→ HDR).
- `in_eot` in HDR, PAYLOAD or CRC: pulse `trunc_err` → IDLE. In IDLE, `in_eot` has no effect.
- `in_vld = 0` stalls all states; counters and CRC hold.
- Error checks are never gated by VC, so errors on filtered VCs still pulse.

## Timing
- All outputs are registered and reset to 0; `pix_dt` resets to 0.
- Latency is 1 cycle from an input byte to its output:
  - `pix_vld`/`pix_dat` appear the cycle after the payload byte is sampled.
  - Sync pulses and `ecc_err` appear the cycle after header byte3.
  - `crc_err` appears the cycle after the second CRC byte.
  - `trunc_err` appears the cycle after `in_sot` or `in_eot` is sampled.
- `pix_last` coincides with the `pix_vld` of the WC-th byte.
- Back-to-back packets are supported: `in_sot` may arrive in the cycle directly after the last CRC byte or after header byte3 of a short packet.
- `areset_n` assertion mid-packet: the state machine returns to IDLE immediately, pulses are dropped, and no error is reported. The first packet after reset release requires a fresh `in_sot`.

## Test plan
- Short packet FS on VC0: bytes 0x00,0x01,0x00,ECC → `frame_start` pulses exactly once, 1 cycle after the ECC byte. No other outputs.
- Long packet DT 0x2A, WC 4, payload 0x11,0x22,0x33,0x44, correct CRC → 4 `pix_vld` beats with matching data and `pix_dt` = 0x2A. `pix_last` asserts on 0x44. No `crc_err`.
- Same packet with the CRC LSB flipped → payload is still forwarded, and `crc_err` pulses once, 1 cycle after the second CRC byte.
- Header with bit 3 of byte1 flipped → `ecc_err` pulses. No `pix_vld` or sync output. The next packet parses normally.
- Long packet WC 8 with `in_eot` after the 3rd payload byte → 3 `pix_vld` beats, `trunc_err` pulse, return to IDLE. A following LE short packet produces `line_end`.
- Long packet on VC1 with `VC_SEL` = 0 and random `in_vld` gaps → no `pix_vld` and no errors. A subsequent VC0 packet with WC 0 produces no `pix_vld` and no `crc_err` when CRC = 0xFFFF.

Source files
------------

// File: rtl/csi2_rx_packet_parser.sv
// CSI-2 receive packet parser: header decode with ECC check, payload CRC check,
// sync pulse generation and VC-filtered payload forwarding. All outputs registered.
module csi2_rx_packet_parser #(
    parameter logic [1:0] VC_SEL    = 2'd0,
    parameter bit         CHECK_ECC = 1'b1
) (
    input  logic       clk,
    input  logic       areset_n,
    input  logic       in_vld,
    input  logic [7:0] in_dat,
    input  logic       in_sot,
    input  logic       in_eot,
    output logic       frame_start,
    output logic       frame_end,
    output logic       line_start,
    output logic       line_end,
    output logic       pix_vld,
    output logic [7:0] pix_dat,
    output logic [5:0] pix_dt,
    output logic       pix_last,
    output logic       ecc_err,
    output logic       crc_err,
    output logic       trunc_err
);

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WC_W   = 16;
    localparam int unsigned CRC_W  = 16;
    localparam int unsigned DT_W   = 6;
    localparam int unsigned IDX_W  = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HDR,
        ST_PAYLOAD,
        ST_CRC
    } state_t;

    // CSI-2 Hamming parity; each mask selects the header bits feeding one ECC bit
    function automatic logic [5:0] ecc_calc(input logic [23:0] d);
        logic [5:0] p;
        p[0] = ^(d & 24'hF12CB7);
        p[1] = ^(d & 24'hF2555B);
        p[2] = ^(d & 24'h749A6D);
        p[3] = ^(d & 24'hB8E38E);
        p[4] = ^(d & 24'hDF03F0);
        p[5] = ^(d & 24'hEFFC00);
        return p;
    endfunction

    // Reflected CRC-16 (0x1021 reversed = 0x8408), one byte per call
    function automatic logic [CRC_W-1:0] crc_step(input logic [CRC_W-1:0] c,
                                                  input logic [BYTE_W-1:0] b);
        logic [CRC_W-1:0] r;
        r = c ^ {8'h00, b};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
        end
        return r;
    endfunction

    state_t             state, state_n;
    logic [IDX_W-1:0]   idx, idx_n;
    logic [BYTE_W-1:0]  dataid, dataid_n;
    logic [BYTE_W-1:0]  wc_lo, wc_lo_n;
    logic [WC_W-1:0]    cnt, cnt_n;
    logic [CRC_W-1:0]   crc, crc_n;
    logic [BYTE_W-1:0]  crc_lo, crc_lo_n;
    logic [BYTE_W-1:0]  pix_dat_n;
    logic [DT_W-1:0]    pix_dt_n;
    logic               fs_n, fe_n, ls_n, le_n;
    logic               pix_vld_n, pix_last_n;
    logic               ecc_err_n, crc_err_n, trunc_err_n;
    logic               vc_match;
    logic [DT_W-1:0]    hdr_dt;

    assign vc_match = (dataid[7:6] == VC_SEL);
    assign hdr_dt   = dataid[5:0];

    // Next-state and next-output logic
    always_comb begin
        state_n     = state;
        idx_n       = idx;
        dataid_n    = dataid;
        wc_lo_n     = wc_lo;
        cnt_n       = cnt;
        crc_n       = crc;
        crc_lo_n    = crc_lo;
        pix_dat_n   = pix_dat;
        pix_dt_n    = pix_dt;
        fs_n        = 1'b0;
        fe_n        = 1'b0;
        ls_n        = 1'b0;
        le_n        = 1'b0;
        pix_vld_n   = 1'b0;
        pix_last_n  = 1'b0;
        ecc_err_n   = 1'b0;
        crc_err_n   = 1'b0;
        trunc_err_n = 1'b0;

        if (in_vld && in_sot) begin
            // A new start always wins; an unfinished packet is reported as truncated
            trunc_err_n = (state != ST_IDLE);
            state_n     = ST_HDR;
            dataid_n    = in_dat;
            idx_n       = IDX_W'(1);
        end else if (in_eot && (state != ST_IDLE)) begin
            trunc_err_n = 1'b1;
            state_n     = ST_IDLE;
        end else if (in_vld) begin
            case (state)
                ST_HDR: begin
                    idx_n = idx + IDX_W'(1);
                    case (idx)
                        2'd1: wc_lo_n = in_dat;
                        2'd2: cnt_n   = {in_dat, wc_lo};
                        default: begin
                            state_n = ST_IDLE;
                            if (CHECK_ECC && ({2'b00, ecc_calc({cnt, dataid})} != in_dat)) begin
                                ecc_err_n = 1'b1;
                            end else if (hdr_dt <= 6'h0F) begin
                                fs_n = vc_match && (hdr_dt == 6'h00);
                                fe_n = vc_match && (hdr_dt == 6'h01);
                                ls_n = vc_match && (hdr_dt == 6'h02);
                                le_n = vc_match && (hdr_dt == 6'h03);
                            end else begin
                                crc_n = 16'hFFFF;
                                idx_n = '0;
                                if (cnt == '0) begin
                                    state_n = ST_CRC;
                                end else begin
                                    state_n = ST_PAYLOAD;
                                    if (vc_match) pix_dt_n = hdr_dt;
                                end
                            end
                        end
                    endcase
                end
                ST_PAYLOAD: begin
                    crc_n = crc_step(crc, in_dat);
                    cnt_n = cnt - WC_W'(1);
                    if (vc_match) begin
                        pix_vld_n  = 1'b1;
                        pix_dat_n  = in_dat;
                        pix_last_n = (cnt == WC_W'(1));
                    end
                    if (cnt == WC_W'(1)) begin
                        state_n = ST_CRC;
                        idx_n   = '0;
                    end
                end
                ST_CRC: begin
                    if (idx == '0) begin
                        crc_lo_n = in_dat;
                        idx_n    = IDX_W'(1);
                    end else begin
                        crc_err_n = ({in_dat, crc_lo} != crc);
                        state_n   = ST_IDLE;
                    end
                end
                default: ;
            endcase
        end
    end

    // State, datapath and output registers
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state       <= ST_IDLE;
            idx         <= '0;
            dataid      <= '0;
            wc_lo       <= '0;
            cnt         <= '0;
            crc         <= '0;
            crc_lo      <= '0;
            frame_start <= 1'b0;
            frame_end   <= 1'b0;
            line_start  <= 1'b0;
            line_end    <= 1'b0;
            pix_vld     <= 1'b0;
            pix_dat     <= '0;
            pix_dt      <= '0;
            pix_last    <= 1'b0;
            ecc_err     <= 1'b0;
            crc_err     <= 1'b0;
            trunc_err   <= 1'b0;
        end else begin
            state       <= state_n;
            idx         <= idx_n;
            dataid      <= dataid_n;
            wc_lo       <= wc_lo_n;
            cnt         <= cnt_n;
            crc         <= crc_n;
            crc_lo      <= crc_lo_n;
            frame_start <= fs_n;
            frame_end   <= fe_n;
            line_start  <= ls_n;
            line_end    <= le_n;
            pix_vld     <= pix_vld_n;
            pix_dat     <= pix_dat_n;
            pix_dt      <= pix_dt_n;
            pix_last    <= pix_last_n;
            ecc_err     <= ecc_err_n;
            crc_err     <= crc_err_n;
            trunc_err   <= trunc_err_n;
        end
    end

endmodule

// File: tb/tb_csi2_rx_packet_parser.sv
// Scoreboard bench for csi2_rx_packet_parser: expected output events (with cycle) are
// queued as bytes are driven and matched against what the parser emits.
module tb_csi2_rx_packet_parser;

    localparam int K_FS = 1, K_FE = 2, K_LS = 3, K_LE = 4, K_PIX = 5,
                   K_ECC = 6, K_CRC = 7, K_TRUNC = 8;

    // ECC syndrome column for each of the 24 header bits
    localparam logic [5:0] ECC_COL [24] = '{
        6'h07, 6'h0B, 6'h0D, 6'h0E, 6'h13, 6'h15, 6'h16, 6'h19,
        6'h1A, 6'h1C, 6'h23, 6'h25, 6'h26, 6'h29, 6'h2A, 6'h2C,
        6'h31, 6'h32, 6'h34, 6'h38, 6'h1F, 6'h2F, 6'h37, 6'h3B
    };

    typedef struct {
        int         kind;
        logic [7:0] dat;
        logic       last;
        logic [5:0] dt;
        int         cyc;
    } ev_t;

    logic       clk = 1'b0;
    logic       areset_n = 1'b0;
    logic       in_vld = 1'b0;
    logic [7:0] in_dat = 8'h00;
    logic       in_sot = 1'b0;
    logic       in_eot = 1'b0;
    logic       frame_start, frame_end, line_start, line_end;
    logic       pix_vld, pix_last, ecc_err, crc_err, trunc_err;
    logic [7:0] pix_dat;
    logic [5:0] pix_dt;

    ev_t        exp_q[$];
    logic [7:0] pl[$];
    int         checks = 0;
    int         failures = 0;
    int         cyc = 0;
    bit         expect_trunc = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc = cyc + 1;

    csi2_rx_packet_parser #(.VC_SEL(2'd0), .CHECK_ECC(1'b1)) dut (
        .clk(clk), .areset_n(areset_n), .in_vld(in_vld), .in_dat(in_dat),
        .in_sot(in_sot), .in_eot(in_eot),
        .frame_start(frame_start), .frame_end(frame_end),
        .line_start(line_start), .line_end(line_end),
        .pix_vld(pix_vld), .pix_dat(pix_dat), .pix_dt(pix_dt), .pix_last(pix_last),
        .ecc_err(ecc_err), .crc_err(crc_err), .trunc_err(trunc_err)
    );

    function automatic logic [5:0] model_ecc(input logic [23:0] d);
        logic [5:0] r = 6'h00;
        for (int i = 0; i < 24; i++) if (d[i]) r ^= ECC_COL[i];
        return r;
    endfunction

    function automatic logic [15:0] model_crc(input logic [7:0] q[$]);
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (q[n]) begin
            for (int j = 0; j < 8; j++) begin
                fb = c[0] ^ q[n][j];
                c  = c >> 1;
                if (fb) c ^= 16'h8408;
            end
        end
        return c;
    endfunction

    // Monitor: every asserted output is one event, popped and compared in fixed order
    always @(negedge clk) begin
        ev_t got, e;
        bit  hit;
        if (areset_n) begin
            for (int k = K_FS; k <= K_TRUNC; k++) begin
                case (k)
                    K_FS:    hit = frame_start;
                    K_FE:    hit = frame_end;
                    K_LS:    hit = line_start;
                    K_LE:    hit = line_end;
                    K_PIX:   hit = pix_vld;
                    K_ECC:   hit = ecc_err;
                    K_CRC:   hit = crc_err;
                    default: hit = trunc_err;
                endcase
                if (hit) begin
                    got.kind = k;
                    got.dat  = (k == K_PIX) ? pix_dat  : 8'h00;
                    got.last = (k == K_PIX) ? pix_last : 1'b0;
                    got.dt   = (k == K_PIX) ? pix_dt   : 6'h00;
                    got.cyc  = cyc;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL unexpected_event kind=%0d dat=%02h cyc=%0d (none expected)",
                                 k, got.dat, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        if (got.kind !== e.kind || got.dat !== e.dat || got.last !== e.last ||
                            got.dt !== e.dt || got.cyc !== e.cyc) begin
                            failures++;
                            $display("FAIL event got kind=%0d dat=%02h last=%0b dt=%02h cyc=%0d exp kind=%0d dat=%02h last=%0b dt=%02h cyc=%0d",
                                     got.kind, got.dat, got.last, got.dt, got.cyc,
                                     e.kind, e.dat, e.last, e.dt, e.cyc);
                        end
                    end
                end
            end
        end
    end

    task automatic idle();
        @(negedge clk);
        in_vld = 1'b0; in_sot = 1'b0; in_eot = 1'b0; in_dat = 8'h00;
    endtask

    task automatic send_byte(input logic [7:0] d, input logic s, input bit gaps);
        if (gaps) repeat ($urandom_range(0, 2)) idle();
        @(negedge clk);
        in_vld = 1'b1; in_dat = d; in_sot = s; in_eot = 1'b0;
    endtask

    task automatic push_ev(input int kind, input logic [7:0] dat, input logic last,
                           input logic [5:0] dt);
        ev_t e;
        e = '{kind, dat, last, dt, cyc + 1};
        exp_q.push_back(e);
    endtask

    // Drives one packet from header fields and pl[], queuing the expected events
    task automatic send_pkt(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc,
                            input bit ecc_bad, input bit crc_bad, input bit gaps,
                            input int eot_after, input int sot_after);
        logic [7:0]  b0, b1, b2, ecc;
        logic [15:0] c;
        b0  = {vc, dt};
        b1  = wc[7:0];
        b2  = wc[15:8];
        ecc = {2'b00, model_ecc({b2, b1, b0})};
        send_byte(b0, 1'b1, gaps);
        if (expect_trunc) begin
            push_ev(K_TRUNC, 8'h00, 1'b0, 6'h00);
            expect_trunc = 1'b0;
        end
        send_byte(ecc_bad ? (b1 ^ 8'h08) : b1, 1'b0, gaps);
        send_byte(b2, 1'b0, gaps);
        send_byte(ecc, 1'b0, gaps);
        if (ecc_bad) begin
            push_ev(K_ECC, 8'h00, 1'b0, 6'h00);
            return;
        end
        if (dt <= 6'h0F) begin
            if (vc == 2'd0 && dt <= 6'h03) push_ev(int'(dt) + 1, 8'h00, 1'b0, 6'h00);
            return;
        end
        for (int i = 0; i < int'(wc); i++) begin
            if (i == eot_after) begin
                @(negedge clk);
                in_vld = 1'b0; in_sot = 1'b0; in_eot = 1'b1;
                push_ev(K_TRUNC, 8'h00, 1'b0, 6'h00);
                idle();
                return;
            end
            if (i == sot_after) begin
                expect_trunc = 1'b1;
                return;
            end
            send_byte(pl[i], 1'b0, gaps);
            if (vc == 2'd0) push_ev(K_PIX, pl[i], (i == int'(wc) - 1), dt);
        end
        c = model_crc(pl);
        send_byte(c[7:0] ^ {7'd0, crc_bad}, 1'b0, gaps);
        send_byte(c[15:8], 1'b0, gaps);
        if (crc_bad) push_ev(K_CRC, 8'h00, 1'b0, 6'h00);
    endtask

    // Bounded drain: idle a few cycles, then every queued event must have been seen
    task automatic drain(input string name);
        repeat (4) idle();
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s_drain pending=%0d required=0", name, exp_q.size());
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        areset_n = 1'b0;
        in_vld = 1'b1; in_sot = 1'b1; in_dat = 8'h2A;
        repeat (3) @(negedge clk);
        checks++;
        if ({frame_start, frame_end, line_start, line_end, pix_vld, pix_last,
             ecc_err, crc_err, trunc_err} !== 9'h000) begin
            failures++;
            $display("FAIL reset_pulses got=%03h required=000",
                     {frame_start, frame_end, line_start, line_end, pix_vld, pix_last,
                      ecc_err, crc_err, trunc_err});
        end
        checks++;
        if (pix_dt !== 6'h00 || pix_dat !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got pix_dt=%02h pix_dat=%02h required 00/00", pix_dt, pix_dat);
        end
        in_vld = 1'b0; in_sot = 1'b0;
        areset_n = 1'b1;
        // Bytes with no start marker must be ignored after reset
        for (int i = 0; i < 6; i++) send_byte(8'h00 + 8'(i), 1'b0, 1'b0);
        drain("reset_no_sot");
    endtask

    task automatic test_short_fs();
        send_pkt(2'd0, 6'h00, 16'h0001, 1'b0, 1'b0, 1'b0, -1, -1);
        drain("short_fs");
    endtask

    task automatic test_long(input bit crc_bad);
        pl = '{8'h11, 8'h22, 8'h33, 8'h44};
        send_pkt(2'd0, 6'h2A, 16'd4, 1'b0, crc_bad, 1'b0, -1, -1);
        drain(crc_bad ? "long_crc_bad" : "long_ok");
        checks++;
        if (pix_dt !== 6'h2A) begin
            failures++;
            $display("FAIL long_pix_dt got=%02h required=2a", pix_dt);
        end
    endtask

    task automatic test_ecc();
        pl = '{8'hA0, 8'hA1, 8'hA2, 8'hA3};
        send_pkt(2'd0, 6'h2A, 16'd4, 1'b1, 1'b0, 1'b0, -1, -1);
        send_pkt(2'd0, 6'h02, 16'h0007, 1'b0, 1'b0, 1'b0, -1, -1);
        drain("ecc_then_ls");
    endtask

    task automatic test_trunc_eot();
        pl = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
        send_pkt(2'd0, 6'h2B, 16'd8, 1'b0, 1'b0, 1'b0, 3, -1);
        send_pkt(2'd0, 6'h03, 16'h0002, 1'b0, 1'b0, 1'b0, -1, -1);
        drain("trunc_eot");
    endtask

    task automatic test_vc_filter();
        pl.delete();
        for (int i = 0; i < 6; i++) pl.push_back(8'($urandom_range(0, 255)));
        send_pkt(2'd1, 6'h2A, 16'd6, 1'b0, 1'b0, 1'b1, -1, -1);
        send_pkt(2'd1, 6'h00, 16'h0003, 1'b0, 1'b0, 1'b1, -1, -1);
        // Errors on a filtered VC still report
        send_pkt(2'd1, 6'h2C, 16'd2, 1'b1, 1'b0, 1'b1, -1, -1);
        pl.delete();
        send_pkt(2'd0, 6'h2B, 16'd0, 1'b0, 1'b0, 1'b1, -1, -1);
        drain("vc_filter");
    endtask

    task automatic test_back_to_back();
        send_pkt(2'd0, 6'h00, 16'h0002, 1'b0, 1'b0, 1'b0, -1, -1);
        pl = '{8'hC1, 8'hC2, 8'hC3};
        send_pkt(2'd0, 6'h24, 16'd3, 1'b0, 1'b0, 1'b0, -1, -1);
        pl = '{8'hD1, 8'hD2, 8'hD3, 8'hD4, 8'hD5};
        send_pkt(2'd0, 6'h1E, 16'd5, 1'b0, 1'b0, 1'b0, -1, 2);
        send_pkt(2'd0, 6'h01, 16'h0002, 1'b0, 1'b0, 1'b0, -1, -1);
        send_pkt(2'd0, 6'h03, 16'h0004, 1'b0, 1'b0, 1'b0, -1, -1);
        drain("back_to_back");
    endtask

    task automatic test_mid_reset();
        pl = '{8'hE1, 8'hE2, 8'hE3, 8'hE4, 8'hE5, 8'hE6};
        send_pkt(2'd0, 6'h2A, 16'd6, 1'b0, 1'b0, 1'b0, -1, 2);
        expect_trunc = 1'b0;
        idle();
        #2 areset_n = 1'b0;
        repeat (2) @(negedge clk);
        areset_n = 1'b1;
        for (int i = 0; i < 6; i++) send_byte(8'hE3 + 8'(i), 1'b0, 1'b0);
        send_pkt(2'd0, 6'h00, 16'h0009, 1'b0, 1'b0, 1'b0, -1, -1);
        drain("mid_reset");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_short_fs();
        test_long(1'b0);
        test_long(1'b1);
        test_ecc();
        test_trunc_eot();
        test_vc_filter();
        test_back_to_back();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
